// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO. Bytes queued by the producer
// are streamed LSB first, and frames run back to back while the FIFO has data.
module uart_tx_fifo #(
  parameter int CLOCK_PER_BIT = 5208,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_TX_data,
  input  logic                          i_TX_valid,
  output logic                          o_TX_ready,
  output logic                          o_TX_bit,
  output logic                          o_TX_busy,
  output logic                          o_TX_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLOCK_PER_BIT > 2) ? $clog2(CLOCK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLOCK_PER_BIT - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_bit_q, tx_bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_en;
  logic          pop;
  logic          bit_end;
  logic          fifo_has_data;

  assign o_TX_ready    = (count_q != COUNT_FULL) && !i_rst;
  assign wr_en         = i_TX_valid && o_TX_ready;
  assign bit_end       = (counter_q == CNT_LAST);
  assign fifo_has_data = (count_q != '0);

  assign o_TX_bit     = tx_bit_q;
  assign o_TX_busy    = busy_q;
  assign o_TX_done    = done_q;
  assign o_fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    tx_bit_d  = tx_bit_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_bit_d  = 1'b1;
        counter_d = '0;
        if (fifo_has_data) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          tx_bit_d  = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          counter_d = '0;
          tx_bit_d  = tx_byte_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          counter_d = '0;
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_bit_d  = tx_byte_q[bit_idx_d];
          end else begin
            tx_bit_d = 1'b1;
            state_d  = STOP;
          end
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          counter_d = '0;
          done_d    = 1'b1;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (fifo_has_data) begin
            pop       = 1'b1;
            tx_byte_d = mem_q[rd_ptr_q];
            tx_bit_d  = 1'b0;
            state_d   = START;
          end else begin
            tx_bit_d = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_bit_d  = 1'b1;
        counter_d = '0;
      end
    endcase

    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_TX_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      counter_q <= '0;
      bit_idx_q <= '0;
      tx_byte_q <= '0;
      tx_bit_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      counter_q <= counter_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
      tx_bit_q  <= tx_bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serial decoder pops expected bytes from a scoreboard,
// while scenario tasks check line waveform, busy/done, count and ready cycle by cycle.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       tx_bit;
  logic       busy;
  logic       done;
  logic [4:0] count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rx_count  = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLOCK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_TX_data    (data),
    .i_TX_valid   (valid),
    .o_TX_ready   (ready),
    .o_TX_bit     (tx_bit),
    .o_TX_busy    (busy),
    .o_TX_done    (done),
    .o_fifo_count (count)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total_cnt, pass_cnt);
    $fatal(1, "watchdog expired");
  end

  // Serial decoder: samples mid-bit on the falling clock edge, aborts on reset.
  initial begin : rx_monitor
    logic prev, ok, start_bit, stop_bit;
    logic [7:0] sh;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && tx_bit === 1'b0) begin
        ok = 1'b1; sh = '0; start_bit = 1'b1; stop_bit = 1'b0;
        for (int k = 1; k <= 9*CPB + CPB/2 && ok; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) ok = 1'b0;
          else if ((k % CPB) == CPB/2) begin
            if (k/CPB == 0)      start_bit = tx_bit;
            else if (k/CPB <= 8) sh[k/CPB - 1] = tx_bit;
            else                 stop_bit = tx_bit;
          end
        end
        if (ok) begin
          rx_count++;
          $display("[%0t] rx byte %02h", $time, sh);
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL rx_byte: got %02h, none expected", sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e) $display("FAIL rx_byte: got %02h expected %02h", sh, e);
            else pass_cnt++;
          end
          total_cnt++;
          if ({start_bit, stop_bit} !== 2'b01)
            $display("FAIL rx_framing: start/stop got %b%b expected 01", start_bit, stop_bit);
          else pass_cnt++;
        end
        prev = 1'b1;
      end else begin
        prev = tx_bit;
      end
    end
  end

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || count !== 5'd0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (n >= budget)
      $display("FAIL %s_drain: queue=%0d busy=%b count=%0d after %0d cycles, required empty/idle",
               name, exp_q.size(), busy, count, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (tx_bit !== 1'b1) $display("FAIL reset_bit: got %b required 1", tx_bit); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d required 0", count); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", ready); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", ready); else pass_cnt++;
    $display("test_reset complete");
  endtask

  // Writes n (1 or 2) bytes on consecutive edges into an idle, empty FIFO and
  // checks line, busy and done on every cycle until the line is idle again.
  task automatic test_wave(input logic [7:0] b0, input logic [7:0] b1, input int n, input string name);
    logic [7:0] cur;
    logic exp_bit, exp_busy, exp_done;
    int f, j;
    valid = 1'b1; data = b0; exp_q.push_back(b0);
    @(posedge clk); #1;
    if (n == 2) begin data = b1; exp_q.push_back(b1); end
    else valid = 1'b0;
    for (int t = 0; t <= n*FRAME; t++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (t >= n*FRAME) begin
        exp_bit = 1'b1;
      end else begin
        f = t / FRAME;
        j = (t % FRAME) / CPB;
        cur = (f == 0) ? b0 : b1;
        if (j == 0)      exp_bit = 1'b0;
        else if (j <= 8) exp_bit = cur[j-1];
        else             exp_bit = 1'b1;
      end
      exp_busy = (t < n*FRAME);
      exp_done = (t > 0) && (t % FRAME == 0);
      total_cnt++;
      if (tx_bit !== exp_bit) $display("FAIL %s_bit t=%0d: got %b required %b", name, t, tx_bit, exp_bit);
      else pass_cnt++;
      total_cnt++;
      if (busy !== exp_busy) $display("FAIL %s_busy t=%0d: got %b required %b", name, t, busy, exp_busy);
      else pass_cnt++;
      total_cnt++;
      if (done !== exp_done) $display("FAIL %s_done t=%0d: got %b required %b", name, t, done, exp_done);
      else pass_cnt++;
    end
    drain(200, name);
    $display("test_wave %s complete", name);
  endtask

  task automatic test_loopback();
    int start_rx;
    start_rx = rx_count;
    valid = 1'b1;
    data = 8'hA3; exp_q.push_back(data); @(posedge clk); #1;
    data = 8'h00; exp_q.push_back(data); @(posedge clk); #1;
    data = 8'hFF; exp_q.push_back(data); @(posedge clk); #1;
    valid = 1'b0;
    drain(500, "loopback");
    total_cnt++;
    if (rx_count - start_rx !== 3) $display("FAIL loopback_count: got %0d bytes required 3", rx_count - start_rx);
    else pass_cnt++;
    $display("test_loopback complete");
  endtask

  task automatic test_burst();
    int exp_c;
    valid = 1'b1; data = 8'hEE; exp_q.push_back(data);
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL burst_busy: got %b required 1", busy); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL burst_start_count: got %0d required 0", count); else pass_cnt++;
    for (int i = 0; i < 17; i++) begin
      valid = 1'b1; data = 8'(i);
      total_cnt++;
      if (ready !== (i < DEPTH)) $display("FAIL burst_ready i=%0d: got %b required %b", i, ready, (i < DEPTH));
      else pass_cnt++;
      if (i < DEPTH) exp_q.push_back(data);
      @(posedge clk); #1;
      exp_c = (i < DEPTH) ? i + 1 : DEPTH;
      total_cnt++;
      if (count !== 5'(exp_c)) $display("FAIL burst_count i=%0d: got %0d required %0d", i, count, exp_c);
      else pass_cnt++;
    end
    valid = 1'b0;
    total_cnt++; if (ready !== 1'b0) $display("FAIL burst_full_ready: got %b required 0", ready); else pass_cnt++;
    drain(2000, "burst");
    $display("test_burst complete");
  endtask

  task automatic test_simul_pop();
    int exp_c;
    valid = 1'b1; data = 8'hA0; exp_q.push_back(data);
    @(posedge clk); #1;
    for (int t = 1; t <= FRAME + 1; t++) begin
      if (t <= DEPTH - 1 || t == FRAME + 1) begin
        valid = 1'b1; data = 8'(8'h40 + t); exp_q.push_back(data);
      end else begin
        valid = 1'b0;
      end
      @(posedge clk); #1;
      exp_c = (t <= DEPTH - 1) ? t : DEPTH - 1;
      total_cnt++;
      if (count !== 5'(exp_c)) $display("FAIL simul_count t=%0d: got %0d required %0d", t, count, exp_c);
      else pass_cnt++;
      if (t >= DEPTH - 1) begin
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL simul_ready t=%0d: got %b required 1", t, ready);
        else pass_cnt++;
      end
    end
    valid = 1'b0;
    total_cnt++; if (done !== 1'b1) $display("FAIL simul_done: got %b required 1", done); else pass_cnt++;
    total_cnt++; if (tx_bit !== 1'b0) $display("FAIL simul_next_start: got %b required 0", tx_bit); else pass_cnt++;
    drain(2000, "simul");
    $display("test_simul_pop complete");
  endtask

  task automatic test_reset_mid_frame();
    valid = 1'b1;
    data = 8'h96; exp_q.push_back(data); @(posedge clk); #1;
    data = 8'h11; exp_q.push_back(data); @(posedge clk); #1;
    data = 8'h22; exp_q.push_back(data); @(posedge clk); #1;
    valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    // Now inside data bit 3 of 0x96 (value 0).
    total_cnt++; if (tx_bit !== 1'b0) $display("FAIL midrst_pre_bit: got %b required 0", tx_bit); else pass_cnt++;
    total_cnt++; if (count !== 5'd2) $display("FAIL midrst_pre_count: got %0d required 2", count); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL midrst_ready_comb: got %b required 0", ready); else pass_cnt++;
    @(posedge clk); #1;
    exp_q.delete();
    total_cnt++; if (tx_bit !== 1'b1) $display("FAIL midrst_bit: got %b required 1", tx_bit); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy); else pass_cnt++;
    total_cnt++; if (count !== 5'd0) $display("FAIL midrst_count: got %0d required 0", count); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL midrst_ready: got %b required 0", ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (done !== 1'b0) $display("FAIL midrst_done i=%0d: got %b required 0", i, done); else pass_cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (tx_bit !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL midrst_idle i=%0d: bit/busy/done got %b%b%b required 100", i, tx_bit, busy, done);
      else pass_cnt++;
    end
    test_wave(8'h3C, 8'h00, 1, "after_reset");
    $display("test_reset_mid_frame complete");
  endtask

  initial begin : main
    test_reset();
    test_wave(8'h55, 8'h00, 1, "single");
    test_wave(8'hC3, 8'h5A, 2, "back_to_back");
    test_loopback();
    test_burst();
    test_simul_pop();
    test_reset_mid_frame();
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
